line_buf_pingpong_ctrl: RTL and testbench

Controller for the 2048x24 simple dual-port line RAM. It splits the RAM into two 1024-pixel banks and writes incoming video lines into them alternately, ping-pong style. It streams completed lines out through a valid/ready interface. It sits between the video input timing domain (already in the system clock) and downstream processing such as a scaler or OSD overlay.

---
 rtl/line_buf_pingpong_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_line_buf_pingpong_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_pingpong_ctrl.sv
// Ping-pong line buffer controller: stores video lines alternately in the two
// halves of a simple dual-port RAM and streams finished lines out over valid/ready.
module line_buf_pingpong_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 24,
    parameter int LINE_MAX   = 2 ** (ADDR_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ovf_flag,
    output logic                  trunc_flag
);
    localparam int CW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LMAX = ADDR_WIDTH'(LINE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} rd_state_e;

    rd_state_e             state_q, state_d;
    logic                  vs_d_q, de_d_q;
    logic                  accepting_q, accepting_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [ADDR_WIDTH-1:0] len_q [2];
    logic                  len_we;
    logic [ADDR_WIDTH-1:0] rd_len_q, rd_len_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic [DATA_WIDTH-1:0] skid_data_q [2];
    logic [DATA_WIDTH-1:0] skid_data_d [2];
    logic [1:0]            skid_last_q, skid_last_d;
    logic                  ovf_q, ovf_d;
    logic                  trunc_q, trunc_d;

    logic                  vs_rise, line_start, line_end, acc_now;
    logic [ADDR_WIDTH-1:0] col_now;
    logic                  pop, rd_issue;
    logic [1:0]            occupancy;

    // The first pixel of a line is written in the same cycle its in_de edge is seen.
    always_comb begin
        vs_rise     = in_vs & ~vs_d_q;
        line_start  = in_de & ~de_d_q & ~vs_rise;
        line_end    = ~in_de & de_d_q;
        acc_now     = line_start ? ~bank_full_q[wr_bank_q] : (accepting_q & ~vs_rise);
        col_now     = line_start ? '0 : col_q;
        ram_wr_en   = in_de & acc_now & (col_now < LMAX);
        ram_wr_addr = {wr_bank_q, col_now[CW-1:0]};
        ram_wr_data = in_data;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d         = state_q;
        accepting_d     = accepting_q;
        col_d           = col_q;
        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        bank_full_d     = bank_full_q;
        len_we          = 1'b0;
        rd_len_d        = rd_len_q;
        rd_cnt_d        = rd_cnt_q;
        skid_cnt_d      = skid_cnt_q;
        skid_data_d     = skid_data_q;
        skid_last_d     = skid_last_q;
        ovf_d           = ovf_q;
        trunc_d         = trunc_q;

        if (line_start) begin
            accepting_d = ~bank_full_q[wr_bank_q];
            if (bank_full_q[wr_bank_q]) ovf_d = 1'b1;
        end
        if (in_de && acc_now) begin
            if (col_now == LMAX) trunc_d = 1'b1;
            else                 col_d   = col_now + 1'b1;
        end
        if (line_end && accepting_q && !vs_rise) begin
            len_we                 = 1'b1;
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            accepting_d            = 1'b0;
        end

        // Issue only when the pixel is guaranteed a skid slot, counting this cycle's pop.
        pop             = out_valid & out_ready;
        occupancy       = skid_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
        rd_issue        = (state_q == S_READ) && (occupancy < 2'd2) && !vs_rise;
        inflight_d      = rd_issue;
        inflight_last_d = rd_issue && ({1'b0, rd_cnt_q} == rd_len_q - 1'b1);

        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = S_READ;
                    rd_cnt_d = '0;
                    rd_len_d = len_q[rd_bank_q];
                end
            end
            S_READ: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (inflight_last_d) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (skid_cnt_q == 2'd0 && !inflight_q) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = ~rd_bank_q;
                    state_d                = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({inflight_q, pop})
            2'b10: begin
                skid_data_d[skid_cnt_q[0]] = ram_rd_data;
                skid_last_d[skid_cnt_q[0]] = inflight_last_q;
                skid_cnt_d                 = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid_data_d[0] = skid_data_q[1];
                skid_last_d[0] = skid_last_q[1];
                skid_cnt_d     = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_data_d[0] = ram_rd_data;
                    skid_last_d[0] = inflight_last_q;
                end else begin
                    skid_data_d[0] = skid_data_q[1];
                    skid_last_d[0] = skid_last_q[1];
                    skid_data_d[1] = ram_rd_data;
                    skid_last_d[1] = inflight_last_q;
                end
            end
            default: ;
        endcase

        if (vs_rise) begin
            state_d         = S_IDLE;
            bank_full_d     = '0;
            wr_bank_d       = 1'b0;
            rd_bank_d       = 1'b0;
            accepting_d     = 1'b0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            skid_cnt_d      = '0;
        end
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            vs_d_q          <= 1'b0;
            de_d_q          <= 1'b0;
            accepting_q     <= 1'b0;
            col_q           <= '0;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            bank_full_q     <= '0;
            rd_len_q        <= '0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            skid_cnt_q      <= '0;
            skid_data_q     <= '{default: '0};
            skid_last_q     <= '0;
            ovf_q           <= 1'b0;
            trunc_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            vs_d_q          <= in_vs;
            de_d_q          <= in_de;
            accepting_q     <= accepting_d;
            col_q           <= col_d;
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            bank_full_q     <= bank_full_d;
            rd_len_q        <= rd_len_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            skid_cnt_q      <= skid_cnt_d;
            skid_data_q     <= skid_data_d;
            skid_last_q     <= skid_last_d;
            ovf_q           <= ovf_d;
            trunc_q         <= trunc_d;
        end
    end

    // NOTE: a length is always written before its bank_full bit rises, so this storage needs no reset.
    always_ff @(posedge clk) begin
        if (len_we) len_q[wr_bank_q] <= col_q;
    end

    assign out_data    = skid_data_q[0];
    assign out_valid   = (skid_cnt_q != 2'd0);
    assign out_last    = out_valid & skid_last_q[0];
    assign ram_rd_addr = {rd_bank_q, rd_cnt_q};
    assign ovf_flag    = ovf_q;
    assign trunc_flag  = trunc_q;

endmodule

// File: tb/tb_line_buf_pingpong_ctrl.sv
// Bench for line_buf_pingpong_ctrl: a line-level model (queues of expected
// pixels) checked every cycle, plus directed scenarios with literal expectations.
module tb_line_buf_pingpong_ctrl;
    localparam int AW   = 11;
    localparam int DW   = 24;
    localparam int LMAX = 1024;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            n;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, in_vs, in_de, out_valid, out_last, out_ready;
    logic          ram_wr_en, ovf_flag, trunc_flag;
    logic [DW-1:0] in_data, out_data, ram_wr_data, ram_rd_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_buf_pingpong_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_MAX(LMAX)) dut (
        .clk(clk), .rst(rst), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ovf_flag(ovf_flag), .trunc_flag(trunc_flag)
    );

    // Line RAM: registered read, data valid one cycle after the address.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    // Model state
    ent_t          exp_q[$];
    ent_t          out_log[$];
    logic [DW-1:0] m_line[$];
    int            wr_log[$];
    int            m_pending, m_bank, commit_n, ncyc, rdy_mode, phase;
    logic          m_acc, m_ovf, m_trunc, m_vs_d, m_de_d;
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_loop();
        logic vs_rise, exp_wr;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                exp_q.delete(); m_line.delete();
                m_pending = 0; m_bank = 0; m_acc = 0; m_ovf = 0; m_trunc = 0;
                m_vs_d = 0; m_de_d = 0; prev_stall = 0;
            end else begin
                if (exp_q.size() == 0) begin
                    check("out_valid_idle", out_valid, 0);
                end else if (out_valid) begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        out_log.push_back('{data: out_data, last: out_last, n: ncyc});
                        if (exp_q[0].last) m_pending--;
                        exp_q.delete(0);
                    end
                end
                if (prev_stall && out_valid) begin
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;

                check("ovf_flag", ovf_flag, m_ovf);
                check("trunc_flag", trunc_flag, m_trunc);
                if (ram_wr_en) wr_log.push_back(int'(ram_wr_addr));

                vs_rise = in_vs && !m_vs_d;
                if (vs_rise) begin
                    exp_q.delete(); m_line.delete();
                    m_pending = 0; m_bank = 0; m_acc = 0;
                end else begin
                    if (in_de && !m_de_d) begin
                        m_acc = (m_pending < 2);
                        if (!m_acc) m_ovf = 1;
                        m_line.delete();
                    end
                    exp_wr = in_de && m_acc && (m_line.size() < LMAX);
                    check("wr_en", ram_wr_en, exp_wr);
                    if (exp_wr) begin
                        check("wr_addr", ram_wr_addr, m_bank * LMAX + m_line.size());
                        check("wr_data", ram_wr_data, in_data);
                    end
                    if (in_de && m_acc) begin
                        if (m_line.size() < LMAX) m_line.push_back(in_data);
                        else m_trunc = 1;
                    end
                    if (!in_de && m_de_d && m_acc) begin
                        foreach (m_line[i])
                            exp_q.push_back('{data: m_line[i], last: (i == m_line.size() - 1), n: 0});
                        m_pending++;
                        m_bank   = 1 - m_bank;
                        m_acc    = 0;
                        commit_n = ncyc;
                    end
                end
                m_vs_d = in_vs;
                m_de_d = in_de;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1; in_vs = 0; in_de = 0; in_data = '0;
        tick(3);
        rst = 0;
        tick(1);
        wr_log.delete();
        out_log.delete();
    endtask

    task automatic send_line(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_de   = 1;
            in_data = DW'(base + i);
            tick();
        end
        in_de   = 0;
        in_data = '0;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            tick();
            k++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic stimulus();
        int k, lasts, bubbles;

        // Reset values
        rst = 1; in_vs = 0; in_de = 0; in_data = '0;
        tick(3);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_trunc", trunc_flag, 0);

        // Single 4-pixel line
        do_reset();
        rdy_mode = 1;
        send_line(4, 1);
        wait_drain(50);
        tick(4);
        check("t1_wr_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < wr_log.size()) check("t1_wr_addr", wr_log[i], i);
        check("t1_out_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_log.size()) begin
                check("t1_data", out_log[i].data, i + 1);
                check("t1_last", out_log[i].last, (i == 3));
                check("t1_consecutive", out_log[i].n - out_log[0].n, i);
            end
        end
        if (out_log.size() > 0) check("t1_latency", out_log[0].n - commit_n, 4);
        check("t1_rd_bank", ram_rd_addr[AW-1], 1);

        // Backpressure, ready pattern 1,0,0
        do_reset();
        rdy_mode = 2;
        send_line(8, 'h10);
        wait_drain(100);
        check("t2_out_count", out_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < out_log.size()) check("t2_data", out_log[i].data, 'h10 + i);

        // Ping-pong: 640-pixel lines, 160-cycle blanking
        do_reset();
        rdy_mode = 1;
        for (int l = 0; l < 4; l++) begin
            send_line(640, l * 'h1000);
            tick(159);
        end
        wait_drain(2000);
        check("t3_ovf", ovf_flag, 0);
        check("t3_out_count", out_log.size(), 2560);
        lasts = 0; bubbles = 0;
        foreach (out_log[i]) begin
            if (out_log[i].last) lasts++;
            if (i > 0 && !out_log[i-1].last && out_log[i].n != out_log[i-1].n + 1) bubbles++;
        end
        check("t3_lines", lasts, 4);
        check("t3_bubbles", bubbles, 0);

        // Overflow: three 16-pixel lines with ready low
        do_reset();
        rdy_mode = 0;
        send_line(16, 'h100); tick(3);
        send_line(16, 'h200); tick(3);
        send_line(16, 'h300); tick(3);
        check("t4_ovf", ovf_flag, 1);
        check("t4_wr_count", wr_log.size(), 32);
        if (wr_log.size() == 32) begin
            check("t4_addr0", wr_log[0], 0);
            check("t4_addr15", wr_log[15], 15);
            check("t4_addr16", wr_log[16], 1024);
            check("t4_addr31", wr_log[31], 1039);
        end
        check("t4_no_out", out_log.size(), 0);
        rdy_mode = 1;
        wait_drain(200);
        check("t4_out_count", out_log.size(), 32);
        if (out_log.size() == 32) begin
            check("t4_first", out_log[0].data, 'h100);
            check("t4_final", out_log[31].data, 'h20f);
        end

        // Truncation: 1030-pixel line
        do_reset();
        rdy_mode = 1;
        send_line(1030, 1);
        wait_drain(1200);
        check("t5_trunc", trunc_flag, 1);
        check("t5_wr_count", wr_log.size(), 1024);
        check("t5_out_count", out_log.size(), 1024);
        lasts = 0;
        foreach (out_log[i]) if (out_log[i].last) lasts++;
        check("t5_last_count", lasts, 1);
        if (out_log.size() == 1024) begin
            check("t5_last_pos", out_log[1023].last, 1);
            check("t5_last_data", out_log[1023].data, 1024);
        end

        // Frame flush mid-read
        do_reset();
        rdy_mode = 1;
        send_line(64, 'h400);
        k = 0;
        while (out_log.size() < 10 && k < 100) begin
            tick();
            k++;
        end
        check("t6_midread", (out_log.size() >= 10), 1);
        in_vs = 1;
        tick();
        in_vs = 0;
        @(negedge clk);
        check("t6_flush_valid", out_valid, 0);
        check("t6_partial", (out_log.size() < 64), 1);
        tick(2);
        wr_log.delete();
        out_log.delete();
        send_line(8, 'h500);
        wait_drain(100);
        check("t6_wr_count", wr_log.size(), 8);
        if (wr_log.size() > 0) check("t6_wr_addr0", wr_log[0], 0);
        check("t6_out_count", out_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < out_log.size()) begin
                check("t6_data", out_log[i].data, 'h500 + i);
                check("t6_last", out_log[i].last, (i == 7));
            end
        end
    endtask

    initial begin
        rst = 1; in_vs = 0; in_de = 0; in_data = '0; out_ready = 0;
        rdy_mode = 0; phase = 0; ncyc = 0; commit_n = 0;
        fork
            model_loop();
            forever begin
                @(posedge clk);
                #1;
                phase++;
                case (rdy_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = (phase % 3 == 0);
                endcase
            end
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
